// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: prioritised stall vector, branch flush and PC redirect,
// with a DRAIN state that waits out an in-flight fetch. Optional perf counters: PIPE_PERF_CNT_EN.
module pipe_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_mem,
  input  logic               if_busy,
  input  logic               if_done,
  input  logic               branch_ex,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               discard_fetch,
  output logic               redirect_valid,
  output logic [ADDR_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0]   perf_stall_cyc,
  output logic [CNT_W-1:0]   perf_flush_cnt
);

  localparam logic [STALL_W-1:0] STALL_MEM = STALL_W'(6'b011111);
  localparam logic [STALL_W-1:0] STALL_ID  = STALL_W'(6'b000111);
  localparam logic [STALL_W-1:0] STALL_IF  = STALL_W'(6'b000011);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic                redir_valid_q, redir_valid_d;
  logic [ADDR_W-1:0]   redir_pc_q, redir_pc_d;
  logic                accept;

  always_comb begin
    stall         = '0;
    flush         = 1'b0;
    discard_fetch = 1'b0;
    accept        = 1'b0;
    state_d       = state_q;
    target_d      = target_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    if (!rst) begin
      // Only the highest-priority request applies; vectors are never merged.
      if (stallreq_mem)
        stall = STALL_MEM;
      else if (stallreq_id)
        stall = STALL_ID;
      else if (stallreq_if || state_q == DRAIN)
        stall = STALL_IF;

      discard_fetch = (state_q == DRAIN);

      case (state_q)
        RUN: begin
          if (branch_ex && !stall[3]) begin
            accept = 1'b1;
            flush  = 1'b1;
            // A fetch finishing this very cycle needs no drain.
            if (if_busy && !if_done) begin
              state_d  = DRAIN;
              target_d = branch_target;
            end else begin
              redir_valid_d = 1'b1;
              redir_pc_d    = branch_target;
            end
          end
        end
        DRAIN: begin
          if (if_done) begin
            state_d       = RUN;
            redir_valid_d = 1'b1;
            redir_pc_d    = target_q;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      target_q      <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cyc_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_q + CNT_W'(stall[0]);
      flush_cnt_q <= flush_cnt_q + CNT_W'(accept);
    end
  end

  assign perf_stall_cyc = stall_cyc_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cyc = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table of single-cycle vectors, hand sequences for
// drain/stall/reset corners, and a redirect scoreboard checked after every clock edge.
module tb_pipe_ctrl;

  localparam int ADDR_W  = 32;
  localparam int STALL_W = 6;
  localparam int CNT_W   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               stallreq_if, stallreq_id, stallreq_mem;
  logic               if_busy, if_done, branch_ex;
  logic [ADDR_W-1:0]  branch_target;
  logic [STALL_W-1:0] stall;
  logic               flush, discard_fetch, redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [CNT_W-1:0]   perf_stall_cyc, perf_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [ADDR_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(ADDR_W), .STALL_W(STALL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
    .if_busy(if_busy), .if_done(if_done),
    .branch_ex(branch_ex), .branch_target(branch_target),
    .stall(stall), .flush(flush), .discard_fetch(discard_fetch),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every expected redirect must appear exactly at the next edge, nothing else may.
  always @(posedge clk) begin
    #1;
    if (redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL redirect_unexpected: got pc 0x%0h expected no redirect", redirect_pc);
      end else begin
        chk("redirect_pc", redirect_pc, exp_q.pop_front());
      end
    end else if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL redirect_missing: got none expected pc 0x%0h", exp_q.pop_front());
    end
  end

  // One cycle: drive at negedge, check combinational outputs, optionally expect a redirect.
  task automatic cyc(input string name, input logic mem, input logic id, input logic ifr,
                     input logic busy, input logic done, input logic br, input logic [31:0] tgt,
                     input logic [5:0] e_stall, input logic e_flush, input logic e_disc,
                     input logic push);
    @(negedge clk);
    rst = 1'b0;
    stallreq_mem = mem; stallreq_id = id; stallreq_if = ifr;
    if_busy = busy; if_done = done; branch_ex = br; branch_target = tgt;
    #1;
    $display("cyc %-10s mem=%b id=%b if=%b busy=%b done=%b br=%b stall=%b flush=%b disc=%b",
             name, mem, id, ifr, busy, done, br, stall, flush, discard_fetch);
    chk({name, ".stall"}, 32'(stall), 32'(e_stall));
    chk({name, ".flush"}, 32'(flush), 32'(e_flush));
    chk({name, ".discard"}, 32'(discard_fetch), 32'(e_disc));
    if (push) exp_q.push_back(tgt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    stallreq_mem = 1'b0; stallreq_id = 1'b0; stallreq_if = 1'b0;
    if_busy = 1'b0; if_done = 1'b0; branch_ex = 1'b0; branch_target = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        mem, id, ifr, busy, done, br;
    logic [31:0] tgt;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic        push;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{"idle",     0,0,0,0,0,0, 32'h0,    6'b000000, 0, 0};
    vt[1] = '{"if",       0,0,1,0,0,0, 32'h0,    6'b000011, 0, 0};
    vt[2] = '{"id",       0,1,0,0,0,0, 32'h0,    6'b000111, 0, 0};
    vt[3] = '{"mem",      1,0,0,0,0,0, 32'h0,    6'b011111, 0, 0};
    vt[4] = '{"all3",     1,1,1,0,0,1, 32'h44,   6'b011111, 0, 0};
    vt[5] = '{"id_if",    0,1,1,0,0,0, 32'h0,    6'b000111, 0, 0};
    vt[6] = '{"br",       0,0,0,0,0,1, 32'h1000, 6'b000000, 1, 1};
    vt[7] = '{"br_id",    0,1,0,0,0,1, 32'h1230, 6'b000111, 1, 1};
    vt[8] = '{"br_mem",   1,0,0,0,0,1, 32'h5550, 6'b011111, 0, 0};
    vt[9] = '{"br_bdone", 0,0,0,1,1,1, 32'h7ac0, 6'b000000, 1, 1};

    // Reset: outputs quiet even with requests asserted.
    @(negedge clk);
    rst = 1'b1;
    stallreq_mem = 1'b1; stallreq_id = 1'b1; stallreq_if = 1'b1;
    if_busy = 1'b0; if_done = 1'b0; branch_ex = 1'b1; branch_target = 32'hdead;
    @(negedge clk);
    #1;
    chk("rst.stall", 32'(stall), 32'h0);
    chk("rst.flush", 32'(flush), 32'h0);
    chk("rst.redirect_valid", 32'(redirect_valid), 32'h0);
    chk("rst.redirect_pc", redirect_pc, 32'h0);

    for (int i = 0; i < 10; i++) begin
      cyc(vt[i].name, vt[i].mem, vt[i].id, vt[i].ifr, vt[i].busy, vt[i].done, vt[i].br,
          vt[i].tgt, vt[i].e_stall, vt[i].e_flush, 1'b0, vt[i].push);
      cyc("gap", 0,0,0,0,0,0, 32'h0, 6'b000000, 0, 0, 0);
    end

    // Branch during in-flight fetch: drain three cycles, redirect after if_done.
    cyc("drn_acc", 0,0,0,1,0,1, 32'h2000, 6'b000000, 1, 0, 0);
    cyc("drn_1",   0,0,0,1,0,1, 32'h9990, 6'b000011, 0, 1, 0);
    cyc("drn_2",   1,0,0,1,0,0, 32'h0,    6'b011111, 0, 1, 0);
    cyc("drn_3",   0,0,0,1,1,0, 32'h2000, 6'b000011, 0, 1, 1);
    cyc("drn_out", 0,0,0,0,0,0, 32'h0,    6'b000000, 0, 0, 0);
    cyc("gap",     0,0,0,0,0,0, 32'h0,    6'b000000, 0, 0, 0);

    // Branch held off by a MEM stall for two cycles.
    cyc("mst_1",   1,0,0,0,0,1, 32'h3000, 6'b011111, 0, 0, 0);
    cyc("mst_2",   1,0,0,0,0,1, 32'h3000, 6'b011111, 0, 0, 0);
    cyc("mst_3",   0,0,0,0,0,1, 32'h3000, 6'b000000, 1, 0, 1);
    cyc("gap",     0,0,0,0,0,0, 32'h0,    6'b000000, 0, 0, 0);

    // Reset while draining: no redirect, back to RUN, redirect_pc cleared.
    cyc("rd_acc",  0,0,0,1,0,1, 32'h4000, 6'b000000, 1, 0, 0);
    cyc("rd_drn",  0,0,0,1,0,0, 32'h0,    6'b000011, 0, 1, 0);
    @(negedge clk);
    rst = 1'b1; if_done = 1'b1; stallreq_if = 1'b1; branch_ex = 1'b1;
    #1;
    chk("rd_rst.stall", 32'(stall), 32'h0);
    chk("rd_rst.discard", 32'(discard_fetch), 32'h0);
    chk("rd_rst.flush", 32'(flush), 32'h0);
    cyc("rd_after", 0,0,0,0,0,0, 32'h0, 6'b000000, 0, 0, 0);
    chk("rd_after.redirect_pc", redirect_pc, 32'h0);
    cyc("rd_after2", 0,0,0,0,1,0, 32'h0, 6'b000000, 0, 0, 0);

    // Performance counters: 5 stalled cycles and 2 accepted branches after reset.
    do_reset();
    for (int i = 0; i < 5; i++)
      cyc("pf_stall", 0,0,1,0,0,0, 32'h0, 6'b000011, 0, 0, 0);
    cyc("pf_br1", 0,0,0,0,0,1, 32'h5000, 6'b000000, 1, 0, 1);
    cyc("gap",    0,0,0,0,0,0, 32'h0,    6'b000000, 0, 0, 0);
    cyc("pf_br2", 0,0,0,0,0,1, 32'h6000, 6'b000000, 1, 0, 1);
    cyc("gap",    0,0,0,0,0,0, 32'h0,    6'b000000, 0, 0, 0);
`ifdef PIPE_PERF_CNT_EN
    chk("perf_stall_cyc", perf_stall_cyc, 32'd5);
    chk("perf_flush_cnt", perf_flush_cnt, 32'd2);
`else
    chk("perf_stall_cyc", perf_stall_cyc, 32'd0);
    chk("perf_flush_cnt", perf_flush_cnt, 32'd0);
`endif

    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
